// File: rtl/hazard_stall_flush_ctrl.sv
// hazard_stall_flush_ctrl
//   Pipeline hazard controller for the fetch/decode and decode/execute
//   registers. It handles three cases:
//   - A load-use hazard causes a one-cycle stall with a bubble.
//   - A multi-cycle decode op causes a counted stall.
//   - A taken branch or jump resolved in execute causes a wrong-path flush.
//   Priority: BranchTaken > MSTALL hold > LoadUse > multi-cycle entry > normal.
//
// Parameters
//   MUL_CYCLES  stall cycles per multi-cycle op (0 disables multi-cycle stalls)
//
// Optional feature
//   HAZARD_STATS_EN  when defined, adds saturating counters StallCycleCount
//                    and FlushCount.
//
// Ports
//   Clk, Reset        clock; synchronous active-high reset
//   IDRs, IDRt        decode source register fields
//   IDUsesRt          decode instruction reads rt
//   IDMultiCycle      decode instruction is a multi-cycle op
//   EXMemRead, EXRt   execute holds a load that writes EXRt
//   BranchTaken       execute resolved a taken branch/jump
//   PCWrite, FTDWrite PC and fetch/decode write enables
//   FTDFlush          fetch/decode flush
//   DTEFlush          decode/execute flush (bubble)
//   Stalling          any stall cycle
module hazard_stall_flush_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRt,
  input  logic        IDMultiCycle,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRt,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        FTDWrite,
  output logic        FTDFlush,
  output logic        DTEFlush,
`ifdef HAZARD_STATS_EN
  output logic [15:0] StallCycleCount,
  output logic [15:0] FlushCount,
`endif
  output logic        Stalling
);

  localparam int CW = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam bit MC_EN = (MUL_CYCLES > 0);
  localparam logic [CW-1:0] CNT_INIT = CW'(MC_EN ? MUL_CYCLES - 1 : 0);

  typedef enum logic {RUN, MSTALL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_use;
  logic          stall;
  logic          flush;

  assign load_use = EXMemRead && (EXRt != 5'd0) &&
                    ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (Reset) begin
      stall = 1'b0;
    end else if (BranchTaken) begin
      flush = 1'b1;
    end else if (state == MSTALL) begin
      // The cycle with cnt==0 is the release cycle: the op moves to execute.
      stall = (cnt != '0);
    end else if (load_use) begin
      stall = 1'b1;
    end else if (IDMultiCycle && MC_EN) begin
      stall = 1'b1;
    end
  end

  assign PCWrite  = !stall;
  assign FTDWrite = !stall;
  assign FTDFlush = flush;
  assign DTEFlush = stall || flush;
  assign Stalling = stall;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (BranchTaken) begin
      // The decode instruction is on the wrong path, so abort any stall.
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        MSTALL: begin
          if (cnt != '0) cnt   <= cnt - CW'(1);
          else           state <= RUN;
        end
        default: begin
          // The entry cycle is itself a stall, so load MUL_CYCLES-1.
          if (!load_use && IDMultiCycle && MC_EN) begin
            state <= MSTALL;
            cnt   <= CNT_INIT;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycleCount <= '0;
      FlushCount      <= '0;
    end else begin
      if (stall && (StallCycleCount != 16'hFFFF)) StallCycleCount <= StallCycleCount + 16'd1;
      if (flush && (FlushCount != 16'hFFFF))      FlushCount      <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_flush_ctrl.sv
module tb_hazard_stall_flush_ctrl;
  localparam int MC = 3;

  logic       Clk = 1'b0;
  logic       Reset, IDUsesRt, IDMultiCycle, EXMemRead, BranchTaken;
  logic [4:0] IDRs, IDRt, EXRt;
  logic       PCWrite, FTDWrite, FTDFlush, DTEFlush, Stalling;
`ifdef HAZARD_STATS_EN
  logic [15:0] StallCycleCount, FlushCount;
`endif

  always #5 Clk = ~Clk;

  hazard_stall_flush_ctrl #(.MUL_CYCLES(MC)) dut (
    .Clk(Clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .IDMultiCycle(IDMultiCycle), .EXMemRead(EXMemRead), .EXRt(EXRt),
    .BranchTaken(BranchTaken), .PCWrite(PCWrite), .FTDWrite(FTDWrite),
    .FTDFlush(FTDFlush), .DTEFlush(DTEFlush),
`ifdef HAZARD_STATS_EN
    .StallCycleCount(StallCycleCount), .FlushCount(FlushCount),
`endif
    .Stalling(Stalling));

  // Expected-output encoding: {PCWrite, FTDWrite, FTDFlush, DTEFlush, Stalling}
  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] STL = 5'b00011;
  localparam logic [4:0] FLS = 5'b11110;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       usesrt, mc, memrd;
    logic [4:0] exrt;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[21];
  int   pass = 0, total = 0;

  // Reference model: tracks whether a multi-cycle op is held and how many
  // stall cycles it has received so far.
  bit in_op;
  int issued;
  int m_sc, m_fc;

  function automatic logic [4:0] model_out();
    bit lu;
    lu = EXMemRead && EXRt != 0 && (EXRt == IDRs || (IDUsesRt && EXRt == IDRt));
    if (Reset)                    return NRM;
    if (BranchTaken)              return FLS;
    if (in_op)                    return (issued < MC) ? STL : NRM;
    if (lu)                       return STL;
    if (IDMultiCycle && MC > 0)   return STL;
    return NRM;
  endfunction

  task automatic model_clock(input logic [4:0] o);
    bit lu;
    lu = EXMemRead && EXRt != 0 && (EXRt == IDRs || (IDUsesRt && EXRt == IDRt));
    if (Reset) begin
      in_op = 0; issued = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (o[0] && m_sc < 65535) m_sc++;
      if (o[2] && m_fc < 65535) m_fc++;
      if (BranchTaken) in_op = 0;
      else if (in_op) begin
        if (issued < MC) issued++;
        else in_op = 0;
      end else if (!lu && IDMultiCycle && MC > 0) begin
        in_op = 1; issued = 1;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; IDRs = v.rs; IDRt = v.rt; IDUsesRt = v.usesrt;
    IDMultiCycle = v.mc; EXMemRead = v.memrd; EXRt = v.exrt; BranchTaken = v.br;
  endtask

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic usesrt, input logic mc, input logic memrd,
                              input logic [4:0] exrt, input logic br, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.usesrt = usesrt; v.mc = mc;
    v.memrd = memrd; v.exrt = exrt; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] dut_out();
    return {PCWrite, FTDWrite, FTDFlush, DTEFlush, Stalling};
  endfunction

  initial begin
    logic [4:0] act, exp;
    //              rst rs  rt  ur mc mr exrt br  exp
    vecs[0]  = mk(1, 5'd8, 5'd0, 0, 1, 1, 5'd8, 0, NRM); // reset forces normal
    vecs[1]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, NRM); // idle
    vecs[2]  = mk(0, 5'd8, 5'd0, 0, 0, 1, 5'd8, 0, STL); // load-use on rs
    vecs[3]  = mk(0, 5'd8, 5'd0, 0, 0, 0, 5'd8, 0, NRM); // load gone
    vecs[4]  = mk(0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, NRM); // r0 never stalls
    vecs[5]  = mk(0, 5'd1, 5'd9, 0, 0, 1, 5'd9, 0, NRM); // rt unused
    vecs[6]  = mk(0, 5'd1, 5'd9, 1, 0, 1, 5'd9, 0, STL); // rt used
    vecs[7]  = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, STL); // mc entry
    vecs[8]  = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, STL); // mc stall 2
    vecs[9]  = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, STL); // mc stall 3
    vecs[10] = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, NRM); // release
    vecs[11] = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, STL); // back-to-back entry
    vecs[12] = mk(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 1, FLS); // branch aborts in 2nd cycle
    vecs[13] = mk(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, NRM); // back to RUN
    vecs[14] = mk(0, 5'd8, 5'd0, 0, 0, 1, 5'd8, 1, FLS); // branch beats load-use
    vecs[15] = mk(0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 0, STL); // load-use with mc pending
    vecs[16] = mk(0, 5'd8, 5'd0, 0, 1, 0, 5'd8, 0, STL); // mc entry next cycle
    vecs[17] = mk(0, 5'd8, 5'd0, 0, 1, 0, 5'd8, 0, STL); // MSTALL, count 2 -> 1
    vecs[18] = mk(1, 5'd8, 5'd0, 0, 1, 0, 5'd8, 0, NRM); // reset while count is 1
    vecs[19] = mk(0, 5'd8, 5'd0, 0, 0, 0, 5'd8, 0, NRM); // RUN after reset
    vecs[20] = mk(0, 5'd8, 5'd0, 0, 0, 0, 5'd8, 0, NRM);

    in_op = 0; issued = 0; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge Clk);
      drive(vecs[i]);
      #1;
      act = dut_out();
      total++;
      if (act === vecs[i].exp) pass++;
      else $display("FAIL vec%0d outs act=%b exp=%b", i, act, vecs[i].exp);
`ifdef HAZARD_STATS_EN
      if (i == 19) begin
        total++;
        if (StallCycleCount === 16'd0 && FlushCount === 16'd0) pass++;
        else $display("FAIL stats_after_reset act=%0d/%0d exp=0/0", StallCycleCount, FlushCount);
      end
`endif
      model_clock(model_out());
    end

    // Hand sequence: MUL_CYCLES=3 held op with branch abort mid-stall,
    // then re-entry giving a full stall count.
    begin
      logic [4:0] seq[7];
      seq = '{STL, STL, FLS, NRM, STL, STL, STL};
      for (int k = 0; k < 7; k++) begin
        @(negedge Clk);
        drive(mk(0, 5'd3, 5'd4, 0, (k != 3), 0, 5'd0, (k == 2), NRM));
        #1;
        act = dut_out();
        total++;
        if (act === seq[k]) pass++;
        else $display("FAIL abort_seq%0d act=%b exp=%b", k, act, seq[k]);
        model_clock(model_out());
      end
    end

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      @(negedge Clk);
      v = mk(($urandom_range(0, 99) < 2), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 35),
             5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 8), NRM);
      drive(v);
      #1;
      act = dut_out();
      exp = model_out();
      total++;
      if (act === exp) pass++;
      else $display("FAIL rand%0d outs act=%b exp=%b", c, act, exp);
`ifdef HAZARD_STATS_EN
      total++;
      if (StallCycleCount === 16'(m_sc) && FlushCount === 16'(m_fc)) pass++;
      else $display("FAIL rand%0d stats act=%0d/%0d exp=%0d/%0d", c,
                    StallCycleCount, FlushCount, m_sc, m_fc);
`endif
      model_clock(exp);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
